// File: rtl/serial_add_seq_if.sv
// Request/operand/result bundle for the bit-serial adder sequencer.
// The master drives requests and operands; the slave (the sequencer) returns status and result.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             rst;
    logic             CIN;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             COUT;

    modport master (
        output start, rst, CIN, sub, op_a, op_b,
        input  busy, done, sum, COUT
    );

    modport slave (
        input  start, rst, CIN, sub, op_a, op_b,
        output busy, done, sum, COUT
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: streams a WIDTH-bit operand pair LSB-first through one full adder.
// Optional macro SERIAL_ADD_SUB_EN enables subtraction (invert B, force carry-in to 1).
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input logic               CLK,
    input logic               NRST,
    serial_add_seq_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_ps;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_c_nxt;
    logic             w_last;
    logic             w_capture;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    assign w_s       = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c_nxt   = maj3(r_a[0], r_b[0], r_carry);
    assign w_last    = (r_cnt == CNT_LAST);
    assign w_capture = (r_state == S_IDLE) && bus.start && !bus.rst;

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: A + ~B + 1, so sub overrides CIN.
    assign w_b_load = bus.sub ? ~bus.op_b : bus.op_b;
    assign w_c_load = bus.sub | bus.CIN;
`else
    logic w_unused_sub;
    assign w_unused_sub = bus.sub;
    assign w_b_load     = bus.op_b;
    assign w_c_load     = bus.CIN;
`endif

    // Next-state decode; the synchronous abort overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.rst) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register with busy/done flopped from the next-state decode.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Serial datapath: operand capture, per-bit add/shift, result load on the last bit.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_ps    <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (bus.rst) begin
            r_cnt   <= '0;
        end else if (w_capture) begin
            r_a     <= bus.op_a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_c_nxt;
            r_ps    <= {w_s, r_ps[WIDTH-1:1]};
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= {w_s, r_ps[WIDTH-1:1]};
                r_cout <= w_c_nxt;
            end else begin
                r_sum  <= r_sum;
                r_cout <= r_cout;
            end
        end else begin
            r_cnt   <= r_cnt;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.COUT = r_cout;
endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq (WIDTH=8): stimulus queues {COUT,sum}, a monitor checks on done.
// Subtraction expectations follow SERIAL_ADD_SUB_EN when it is defined for the build.
module tb_serial_add_seq;
    logic clk;
    logic nrst;

    int checks;
    int errors;

    logic [8:0] exp_q[$];

    serial_add_seq_if #(.WIDTH(8)) bus ();

    serial_add_seq #(.WIDTH(8)) dut (
        .CLK  (clk),
        .NRST (nrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pop expected result on every done pulse; busy and done must never overlap.
    always @(negedge clk) begin
        if (nrst) begin
            check("busy_done_exclusive", {31'd0, bus.busy & bus.done}, 32'd0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("result", {23'd0, bus.COUT, bus.sum}, {23'd0, e});
                end
            end
        end
    end

    // Caller is in an IDLE cycle; returns one cycle later with operands scrambled.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic sb, input logic [8:0] exp, input bit push);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.CIN   = cin;
        bus.sub   = sb;
        bus.start = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op_a  = 8'($urandom);
        bus.op_b  = 8'($urandom);
        bus.CIN   = 1'($urandom);
        bus.sub   = 1'($urandom);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 30 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        nrst      = 1'b0;
        bus.start = 1'b0;
        bus.rst   = 1'b0;
        bus.CIN   = 1'b0;
        bus.sub   = 1'b0;
        bus.op_a  = 8'h00;
        bus.op_b  = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum",  {24'd0, bus.sum},  32'd0);
        check("rst_cout", {31'd0, bus.COUT}, 32'd0);
        nrst = 1'b1;
        @(posedge clk); #1;

        // Basic add with cycle-accurate busy/done timing.
        start_op(8'h5A, 8'h3C, 1'b0, 1'b0, {1'b0, 8'h96}, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("t1_busy_c%0d", k), {31'd0, bus.busy}, {31'd0, (k <= 8) ? 1'b1 : 1'b0});
            check($sformatf("t1_done_c%0d", k), {31'd0, bus.done}, {31'd0, (k == 9) ? 1'b1 : 1'b0});
            if (k < 9) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;

        // Carry-out boundaries.
        start_op(8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 8'h00}, 1'b1);
        wait_done();
        start_op(8'hFF, 8'h00, 1'b1, 1'b0, {1'b1, 8'h00}, 1'b1);
        wait_done();

        // Abort in RUN cycle 4 after a 0x96 result.
        start_op(8'h5A, 8'h3C, 1'b0, 1'b0, {1'b0, 8'h96}, 1'b1);
        wait_done();
        start_op(8'h01, 8'h01, 1'b0, 1'b0, 9'd0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.rst = 1'b1;
        @(posedge clk); #1;
        bus.rst = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_sum",  {24'd0, bus.sum},  32'h96);
        check("abort_cout", {31'd0, bus.COUT}, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_sum_hold", {24'd0, bus.sum}, 32'h96);

        // start and rst together in IDLE: nothing captured.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.rst   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.rst   = 1'b0;
        @(negedge clk);
        check("start_rst_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;

        // start held high: done at cycles 9, 19, 29.
        bus.op_a  = 8'h10;
        bus.op_b  = 8'h20;
        bus.CIN   = 1'b0;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        repeat (3) exp_q.push_back({1'b0, 8'h30});
        for (int c = 1; c <= 29; c++) begin
            @(posedge clk); #1;
            if (c == 29) bus.start = 1'b0;
            @(negedge clk);
            check($sformatf("held_done_c%0d", c), {31'd0, bus.done},
                  {31'd0, (c == 9 || c == 19 || c == 29) ? 1'b1 : 1'b0});
        end
        @(posedge clk); #1;

        // Subtract request.
`ifdef SERIAL_ADD_SUB_EN
        start_op(8'h10, 8'h01, 1'b0, 1'b1, {1'b1, 8'h0F}, 1'b1);
        wait_done();
        start_op(8'h01, 8'h02, 1'b0, 1'b1, {1'b0, 8'hFF}, 1'b1);
        wait_done();
`else
        start_op(8'h10, 8'h01, 1'b0, 1'b1, {1'b0, 8'h11}, 1'b1);
        wait_done();
        start_op(8'h01, 8'h02, 1'b0, 1'b1, {1'b0, 8'h03}, 1'b1);
        wait_done();
`endif

        // Asynchronous NRST mid-RUN, then a clean operation.
        start_op(8'hC3, 8'h5F, 1'b1, 1'b0, 9'd0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        nrst = 1'b0;
        #2;
        check("nrst_busy", {31'd0, bus.busy}, 32'd0);
        check("nrst_done", {31'd0, bus.done}, 32'd0);
        check("nrst_sum",  {24'd0, bus.sum},  32'd0);
        check("nrst_cout", {31'd0, bus.COUT}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        start_op(8'h5A, 8'h3C, 1'b0, 1'b0, {1'b0, 8'h96}, 1'b1);
        wait_done();
        start_op(8'h7F, 8'h80, 1'b1, 1'b0, {1'b1, 8'h00}, 1'b1);
        wait_done();

        repeat (2) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
